// File: rtl/core_pkg.sv
// Shared RV32I core constants: datapath sizing and write-back select encodings.
package core_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef enum logic [2:0] {
    WB_ALU   = 3'b000,
    WB_MEM   = 3'b001,
    WB_AUIPC = 3'b010,
    WB_PC4   = 3'b011,
    WB_IMM   = 3'b111
  } wb_sel_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one busy bit per architectural register plus the
// decode hazard, which a same-cycle write-back to the read register suppresses.
module reg_scoreboard #(
  parameter int NREGS = core_pkg::NREGS,
  parameter int AW    = core_pkg::AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pend_set,
  input  logic [AW-1:0]    pend_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [NREGS-1:0] busy_vec,
  output logic             hazard
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  assign busy_d[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
      // A new load issue outranks the write-back retiring the previous one.
      always_comb begin
        busy_d[gi] = busy_q[gi];
        if (pend_set && (pend_addr == AW'(gi))) begin
          busy_d[gi] = 1'b1;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          busy_d[gi] = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  logic rs1_haz;
  logic rs2_haz;

  always_comb begin
    rs1_haz = busy_q[rs1_addr] && !(wr_en && (wr_addr == rs1_addr));
    rs2_haz = busy_q[rs2_addr] && !(wr_en && (wr_addr == rs2_addr));
  end

  assign hazard   = rs1_haz || rs2_haz;
  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_rd.sv
// RV32I architectural register file: x0 hardwired to zero, two combinational
// read ports with write-through bypass, and a pending-load scoreboard.
module reg_file_rd #(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int NREGS = core_pkg::NREGS,
  parameter int AW    = core_pkg::AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [XLEN-1:0]  wr_data,
  input  logic             pend_set,
  input  logic [AW-1:0]    pend_addr,
  output logic             hazard,
  output logic [NREGS-1:0] busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass lets decode consume a value in the same cycle it is written back.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (wr_en && (wr_addr == rs1_addr)) begin
      rs1_data = wr_data;
    end
  end

  always_comb begin
    rs2_data = regs_q[rs2_addr];
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (wr_en && (wr_addr == rs2_addr)) begin
      rs2_data = wr_data;
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .busy_vec  (busy_vec),
    .hazard    (hazard)
  );

endmodule

// File: tb/tb_reg_file_rd.sv
// Directed and randomized bench for reg_file_rd against an array-based model.
module tb_reg_file_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pend_set;
  logic [4:0]  pend_addr;
  logic        hazard;
  logic [31:0] busy_vec;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_regs [32];
  logic        ref_busy [32];

  always #5 clk = ~clk;

  reg_file_rd dut (
    .clk       (clk),
    .rst       (rst),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .hazard    (hazard),
    .busy_vec  (busy_vec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return ref_regs[a];
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = ref_busy[i];
    return v;
  endfunction

  function automatic logic exp_hazard();
    logic h1 = ref_busy[rs1_addr] && !(wr_en && wr_addr == rs1_addr);
    logic h2 = ref_busy[rs2_addr] && !(wr_en && wr_addr == rs2_addr);
    return h1 || h2;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rs1"},    rs1_data,          exp_read(rs1_addr));
    chk({tag, ".rs2"},    rs2_data,          exp_read(rs2_addr));
    chk({tag, ".busy"},   busy_vec,          exp_busy());
    chk({tag, ".hazard"}, {31'b0, hazard},   {31'b0, exp_hazard()});
  endtask

  // Apply the architectural update rules at a clock edge.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        ref_regs[i] = '0;
        ref_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        ref_regs[wr_addr] = wr_data;
        ref_busy[wr_addr] = 1'b0;
      end
      if (pend_set && pend_addr != 0) ref_busy[pend_addr] = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; pend_set = 0; pend_addr = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref_regs[i] = 'x;
      ref_busy[i] = 1'b0;
    end
    rst = 1; rs1_addr = 0; rs2_addr = 0;
    idle();
    cycle();
    rst = 0;

    // Reset state across all indices
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
      #1;
      check_all($sformatf("reset_rd%0d", a));
      chk("reset_rs1_zero", rs1_data, 32'h0);
    end

    // Write to x0 is discarded
    wr_en = 1; wr_addr = 0; wr_data = 32'hDEADBEEF; rs1_addr = 0;
    #1; chk("x0_bypass", rs1_data, 32'h0);
    cycle(); idle(); #1;
    chk("x0_read", rs1_data, 32'h0);
    chk("x0_busy", busy_vec, 32'h0);

    // Write-through bypass then storage read of x5
    wr_en = 1; wr_addr = 5; wr_data = 32'h1234_5678; rs1_addr = 5;
    #1; chk("x5_bypass", rs1_data, 32'h1234_5678);
    cycle(); idle(); #1;
    chk("x5_store", rs1_data, 32'h1234_5678);

    // Pending load on x7, resolved by a write-back
    pend_set = 1; pend_addr = 7;
    cycle(); idle(); rs2_addr = 7; #1;
    chk("x7_hazard", {31'b0, hazard}, 32'd1);
    chk("x7_busy_set", busy_vec, 32'h80);
    wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5; #1;
    chk("x7_resolve_hz", {31'b0, hazard}, 32'd0);
    chk("x7_resolve_rd", rs2_data, 32'hA5A5A5A5);
    cycle(); idle(); #1;
    chk("x7_busy_clr", {31'b0, busy_vec[7]}, 32'd0);
    check_all("x7_after");

    // Simultaneous set and clear on x9: set wins, data still written
    pend_set = 1; pend_addr = 9;
    cycle();
    pend_set = 1; pend_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h0BAD_F00D;
    cycle(); idle(); rs1_addr = 9; #1;
    chk("x9_busy", {31'b0, busy_vec[9]}, 32'd1);
    chk("x9_data", rs1_data, 32'h0BAD_F00D);
    wr_en = 1; wr_addr = 9; wr_data = 32'h0;
    cycle(); idle(); #1;

    // Reset mid-operation overrides write and clears scoreboard
    wr_en = 1; wr_addr = 3; wr_data = 32'hFFFF_FFFF; pend_set = 1; pend_addr = 4;
    cycle(); idle(); rs1_addr = 3; rs2_addr = 4; #1;
    chk("pre_rst_x3", rs1_data, 32'hFFFF_FFFF);
    chk("pre_rst_hz", {31'b0, hazard}, 32'd1);
    rst = 1; wr_en = 1; wr_addr = 3; wr_data = 32'h7777_7777; #1;
    chk("rst_bypass", rs1_data, 32'h7777_7777);
    cycle(); rst = 0; idle(); #1;
    chk("rst_x3", rs1_data, 32'h0);
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_hz", {31'b0, hazard}, 32'd0);

    // Randomized traffic, biased toward a few registers so collisions happen
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      wr_en     = $urandom_range(0, 1) == 1;
      wr_addr   = 5'($urandom_range(0, 7));
      wr_data   = $urandom;
      pend_set  = $urandom_range(0, 2) == 0;
      pend_addr = 5'($urandom_range(0, 7));
      rs1_addr  = 5'($urandom_range(0, 9));
      rs2_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
      #1;
      check_all($sformatf("rand%0d", n));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_rd.md
# reg_file_rd

Architectural register file for the single-cycle/pipelined RV32I core. It holds x0–x31 and is written from the write-back select path. It serves two combinational read ports to decode with write-through bypass. It also keeps a per-register pending-write scoreboard so decode can detect a read of a register whose load result has not yet returned.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers; x0 is hardwired zero
- AW, 5, register index width, log2(NREGS)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rs1_addr  input  AW  read port 1 index
- rs2_addr  input  AW  read port 2 index
- rs1_data  output  XLEN  read port 1 data (combinational)
- rs2_data  output  XLEN  read port 2 data (combinational)
- wr_en  input  1  write-back strobe
- wr_addr  input  AW  write-back destination index
- wr_data  input  XLEN  write-back value, from the write-back select mux
- pend_set  input  1  decode issues a long-latency (load) write to pend_addr
- pend_addr  input  AW  destination of the issued load
- hazard  output  1  rs1 or rs2 targets a pending register that is not being resolved this cycle
- busy_vec  output  NREGS  current scoreboard bits, for debug and the bench

## Operation
- Storage:
  - NREGS × XLEN flops.
  - On reset, all registers are 0 and busy_vec is 0.
- Write:
  - If wr_en=1 and wr_addr≠0, regs[wr_addr] takes wr_data at the next edge.
  - Writes to x0 are discarded.
- Read:
  - If rsN_addr=0, rsN_data=0.
  - Else, if wr_en=1 and wr_addr=rsN_addr, rsN_data=wr_data (write-through bypass).
  - Else, rsN_data=regs[rsN_addr].
- Scoreboard, per register i≠0. Each edge, busy[i] takes:
  - 1 if pend_set=1 and pend_addr=i (set wins over a simultaneous clear).
  - Else 0 if wr_en=1 and wr_addr=i.
  - Else it holds.
- busy[0] is constant 0. pend_set with pend_addr=0 is ignored.
- hazard = (busy[rs1_addr] & ~(wr_en & wr_addr=rs1_addr)) | (the same term for rs2). A write-back in the same cycle resolves the hazard because of the bypass.
- A second pend_set to an already-busy register keeps it busy; there is no counting. One write-back clears it.
- Reset asserted mid-operation: all registers and busy bits are 0 after that edge. Reset overrides any same-cycle wr_en or pend_set.

## Timing
- Read latency is 0 cycles (combinational from addresses, wr_en, wr_addr and wr_data).
- Write latency is 1 edge. Data is visible through storage from the cycle after the edge, and through the bypass in the same cycle.
- busy set or clear is visible on busy_vec and hazard from the cycle after the pend_set or wr_en edge.
- hazard is combinational from the current busy_vec and the read and write addresses.
- Outputs during reset cycles:
  - rsN_data is 0 at the next cycle. Bypass still applies combinationally while rst is high.
  - hazard is 0 once busy_vec has cleared.

## Structure
- Shared package core_pkg holds:
  - XLEN, NREGS, AW.
  - The write-back select encodings: WB_ALU=3'b000, WB_MEM=3'b001, WB_AUIPC=3'b010, WB_PC4=3'b011, WB_IMM=3'b111.
- One sub-module, reg_scoreboard:
  - Contains the busy flops, set/clear priority and hazard logic.
  - Ports: clk, rst, pend_set, pend_addr, wr_en, wr_addr, rs1_addr, rs2_addr, busy_vec, hazard.
- The top level holds the storage array and bypass muxes.

## Test plan
- Reset, then read all 32 indices.
  - Every rsN_data is 0, busy_vec=0, hazard=0.
- Write x0:
  - wr_en=1, wr_addr=0, wr_data=32'hDEADBEEF.
  - Next cycle rs1_addr=0 returns 0, and busy_vec is unchanged.
- Write then read x5 (wr_addr=5, wr_data=32'h1234_5678):
  - Same cycle: rs1_addr=5 returns 32'h1234_5678 via bypass.
  - Next cycle with wr_en=0: it returns the same value from storage.
- Load pending on x7:
  - pend_set=1, pend_addr=7. Next cycle rs2_addr=7 gives hazard=1.
  - Then wr_en=1, wr_addr=7, wr_data=32'hA5A5A5A5 in a cycle with rs2_addr=7: hazard=0 and rs2_data=32'hA5A5A5A5.
  - Following cycle: busy_vec[7]=0.
- Same-cycle set and clear on x9:
  - busy[9]=1, with pend_set=1, pend_addr=9 and wr_en=1, wr_addr=9 together.
  - After the edge, busy[9]=1 and regs[9]=wr_data.
- Reset mid-operation:
  - x3=32'hFFFF_FFFF and busy[4]=1. Assert rst for one cycle together with wr_en=1, wr_addr=3.
  - After the edge, reading x3 gives 0, busy_vec=0, hazard=0.
